// File: rtl/sprite_pkg.sv
// Shared screen geometry, bus widths and coordinate/colour types for the sprite datapath.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COLOR_W  = 5;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_idx_t;

  // Counter width that stays legal (>= 1 bit) for a modulus of 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_counter.sv
// Animation sequencer: divides frame_start pulses by ANIM_DIV and steps anim_frame modulo NUM_FRAMES.
module sprite_anim_counter import sprite_pkg::*; #(
  parameter  int unsigned NUM_FRAMES = 4,
  parameter  int unsigned ANIM_DIV   = 8,
  localparam int unsigned FRAME_W    = cnt_w(NUM_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int unsigned DIV_W = cnt_w(ANIM_DIV);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (frame_start && anim_en) begin
      if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign anim_frame = frame_q;

endmodule

// File: rtl/sprite_fetch.sv
// Per-pixel sprite fetch: hit test, frame-RAM addressing, flip/transparency and a 3-cycle
// pipeline that absorbs the RAM's one-cycle read latency.
module sprite_fetch import sprite_pkg::coord_t, sprite_pkg::cnt_w; #(
  parameter  int unsigned SPRITE_W    = 20,
  parameter  int unsigned SPRITE_H    = 20,
  parameter  int unsigned NUM_FRAMES  = 4,
  parameter  int unsigned ANIM_DIV    = 8,
  parameter  int unsigned ADDR_W      = 19,
  parameter  int unsigned COLOR_W     = 5,
  parameter  int unsigned TRANSPARENT = 0,
  localparam int unsigned FRAME_W     = cnt_w(NUM_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  coord_t             DrawX,
  input  coord_t             DrawY,
  input  logic               frame_start,
  input  coord_t             sprite_x,
  input  coord_t             sprite_y,
  input  logic               sprite_en,
  input  logic               flip_h,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [COLOR_W-1:0] ram_data,
  output logic               pixel_valid,
  output logic [COLOR_W-1:0] pixel_index,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;
  localparam int unsigned EXT_W    = $bits(coord_t) + 1;

  coord_t lx_q, lx_d, ly_q, ly_d;
  logic   len_q, len_d, lflip_q, lflip_d;

  logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
  logic               hit_d1_q, hit_d1_d, hit_d2_q, hit_d2_d;
  logic               pix_valid_q, pix_valid_d;
  logic [COLOR_W-1:0] pix_index_q, pix_index_d;

  sprite_anim_counter #(
    .NUM_FRAMES (NUM_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .anim_frame  (anim_frame)
  );

  // One-bit-wider compare so a sprite near x/y=1023 never wraps onto column 0.
  logic [EXT_W-1:0] x_ext, y_ext, lx_ext, ly_ext;
  logic             hit_c;
  coord_t           dx_c, dy_c;
  logic [ADDR_W-1:0] col_c, addr_c;

  assign x_ext  = EXT_W'(DrawX);
  assign y_ext  = EXT_W'(DrawY);
  assign lx_ext = EXT_W'(lx_q);
  assign ly_ext = EXT_W'(ly_q);

  assign hit_c = len_q
               && (x_ext >= lx_ext) && (x_ext < lx_ext + EXT_W'(SPRITE_W))
               && (y_ext >= ly_ext) && (y_ext < ly_ext + EXT_W'(SPRITE_H));

  assign dx_c   = DrawX - lx_q;
  assign dy_c   = DrawY - ly_q;
  assign col_c  = lflip_q ? ADDR_W'(SPRITE_W - 1) - ADDR_W'(dx_c) : ADDR_W'(dx_c);
  assign addr_c = ADDR_W'(anim_frame) * ADDR_W'(FRAME_SZ)
                + ADDR_W'(dy_c) * ADDR_W'(SPRITE_W) + col_c;

  always_comb begin
    lx_d        = lx_q;
    ly_d        = ly_q;
    len_d       = len_q;
    lflip_d     = lflip_q;
    read_addr_d = hit_c ? addr_c : '0;
    hit_d1_d    = hit_c;
    hit_d2_d    = hit_d1_q;
    pix_valid_d = hit_d2_q && (ram_data != COLOR_W'(TRANSPARENT));
    pix_index_d = pix_valid_d ? ram_data : '0;
    // Position is only sampled at vblank so a frame is never drawn half old, half new.
    if (frame_start) begin
      lx_d    = sprite_x;
      ly_d    = sprite_y;
      len_d   = sprite_en;
      lflip_d = flip_h;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lx_q        <= '0;
      ly_q        <= '0;
      len_q       <= 1'b0;
      lflip_q     <= 1'b0;
      read_addr_q <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
    end else begin
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      len_q       <= len_d;
      lflip_q     <= lflip_d;
      read_addr_q <= read_addr_d;
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d2_d;
      pix_valid_q <= pix_valid_d;
      pix_index_q <= pix_index_d;
    end
  end

  assign read_address = read_addr_q;
  assign pixel_valid  = pix_valid_q;
  assign pixel_index  = pix_index_q;

endmodule
